bp_be_late_wb_arbiter: RTL and testbench
========================================

Name: bp_be_late_wb_arbiter

Overview:
- Arbitrates post-commit ("late") register-file writebacks from long-latency producers onto the shared late integer and late FP writeback channels: dcache load-miss fills, the iterative integer divider and the FP divider/sqrt.
- Its outputs drive the late iwb/fwb packets that clear the int/fp scoreboards in the issue-stage hazard detector.
- One grant per channel per cycle, round-robin among requesters.
- The RF write is registered one cycle after the grant.

Parameters:
- num_req_p, 3, number of requesters; index 0 = dcache, 1 = idiv, 2 = fdiv.
- data_width_p, 64, writeback data width (dword).
- reg_addr_width_p, 5, architectural register address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester writeback valid.
- req_fp_i  in  num_req_p  1 = targets FP RF (fwb channel), 0 = integer RF (iwb channel).
- req_rd_addr_i  in  num_req_p*reg_addr_width_p  destination register, requester i at slice i.
- req_data_i  in  num_req_p*data_width_p  writeback data, requester i at slice i.
- req_yumi_o  out  num_req_p  same-cycle grant/consume of requester i.
- iwb_busy_i  in  1  early integer writeback owns the int RF write port next cycle.
- fwb_busy_i  in  1  early FP writeback owns the FP RF write port next cycle.
- iwb_v_o  out  1  late integer writeback valid (RF write and int scoreboard clear).
- iwb_rd_addr_o  out  reg_addr_width_p  late integer rd.
- iwb_data_o  out  data_width_p  late integer data.
- fwb_v_o  out  1  late FP writeback valid (FP RF write and fp scoreboard clear).
- fwb_rd_addr_o  out  reg_addr_width_p  late FP rd.
- fwb_data_o  out  data_width_p  late FP data.

Behaviour:
- Handshake is valid/yumi.
  - Producers hold req_v_i, req_fp_i, rd and data stable until yumi; an assertion checks this.
  - req_yumi_o is combinational from the current-cycle inputs and arbiter state.
  - A producer must not depend on yumi to raise v.
- Channel steering: requester i competes on the iwb channel when req_fp_i[i]=0, on the fwb channel when 1. The two channels arbitrate independently, so two different requesters can both be granted in one cycle.
- Per-channel round-robin:
  - pointer ptr (clog2(num_req_p) bits), reset 0.
  - Winner = first requesting index at or after ptr, wrapping modulo num_req_p.
  - On a grant, ptr <= winner+1, wrapping num_req_p-1 -> 0. Without a grant, ptr holds.
- Grant condition (base build): channel busy_i low and at least one eligible request. If busy_i is high, no grant on that channel; the requester keeps waiting.
- Output timing:
  - A grant in cycle N makes the *_v_o pulse high exactly in cycle N+1, for one cycle, with the winner's rd and data registered.
  - With no grant in cycle N, *_v_o = 0 in N+1. rd/data outputs are don't-care when v=0 but must be registered (no combinational path from req_*).
- Reset:
  - All *_v_o = 0 and req_yumi_o = 0 in the reset cycle.
  - Both ptrs = 0.
  - A grant pending in the output register at reset is dropped; v=0 the cycle after reset.
- Boundaries:
  - num_req_p=1 degenerates to a pass-through register with ptr constant 0.
  - A request arriving in the same cycle as busy drops waits; it is not granted until busy_i is sampled low.
- No flush input: late writebacks are architecturally committed and must never be dropped outside reset.

Optional Feature:
- Macro: BP_BE_LATE_WB_HOLD_EN.
- Enabled: each channel has a 1-entry hold register (valid, rd, data), reset empty.
  - Hold empty: grant regardless of busy_i. If busy_i=0, the winner goes to the output register; otherwise the winner goes to hold.
  - Hold full: no grant. If busy_i=0, hold moves to the output register and hold clears; a new grant is possible the following cycle.
  - Hold is never overwritten while full.
- Disabled: no hold register; grants are gated by ~busy_i as described under Behaviour.

Test Plan:
- Single request: req_v_i=3'b010, fp=0, rd=5'd7, data=64'hDEAD -> yumi[1]=1 in cycle N; iwb_v_o=1, rd 7, data DEAD in N+1 only; fwb_v_o=0.
- Round-robin: req_v_i=3'b111 all int, held continuously and re-raised after each yumi -> grant order 0,1,2,0; ptr wraps 2->0.
- Dual channel: req0 int rd 3, req2 fp rd 9, same cycle -> both yumi; iwb_v_o and fwb_v_o both high next cycle with rd 3 and 9.
- Busy stall: iwb_busy_i=1 for 4 cycles with req1 int pending -> no yumi for 4 cycles; yumi in the first busy-low cycle; iwb_v_o one cycle later. With HOLD_EN: yumi in cycle 0, iwb_v_o one cycle after busy drops.
- Reset mid-operation: grant in cycle N, reset_i asserted in N+1 -> iwb_v_o=0 in N+1 and N+2; ptr=0; a first request after reset with req_v_i=3'b110 grants index 1.
- HOLD_EN full: hold full, busy high, req0 pending -> no yumi; busy drops -> hold output; req0 granted the next cycle.

Source files
------------

// File: rtl/bp_be_late_wb_arbiter.sv
// ---------------------------------------------------------------------------
// bp_be_late_wb_arbiter
//
// Purpose: arbitrates post-commit ("late") register-file writebacks from
// long-latency producers (0 = dcache miss fill, 1 = idiv, 2 = fdiv) onto the
// shared late integer (iwb) and late FP (fwb) writeback channels. Each channel
// runs an independent round-robin arbiter and grants at most once per cycle.
// The RF write is registered one cycle after the grant.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   req_v_i             per-requester writeback valid
//   req_fp_i            per-requester channel select (1 = fwb, 0 = iwb)
//   req_rd_addr_i       per-requester destination register (slice i)
//   req_data_i          per-requester writeback data (slice i)
//   req_yumi_o          same-cycle consume of requester i (combinational)
//   iwb_busy_i          early int writeback owns the int RF port next cycle
//   fwb_busy_i          early FP writeback owns the FP RF port next cycle
//   iwb_v_o/rd/data     late integer writeback packet (registered)
//   fwb_v_o/rd/data     late FP writeback packet (registered)
//
// Optional feature: define BP_BE_LATE_WB_HOLD_EN to add a 1-entry hold
// register per channel so a grant can be taken while the channel is busy.
// ---------------------------------------------------------------------------
module bp_be_late_wb_arbiter #(
    parameter int unsigned num_req_p        = 3,
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned reg_addr_width_p = 5
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p-1:0]                   req_fp_i,
    input  logic [num_req_p*reg_addr_width_p-1:0]  req_rd_addr_i,
    input  logic [num_req_p*data_width_p-1:0]      req_data_i,
    output logic [num_req_p-1:0]                   req_yumi_o,

    input  logic                                   iwb_busy_i,
    input  logic                                   fwb_busy_i,

    output logic                                   iwb_v_o,
    output logic [reg_addr_width_p-1:0]            iwb_rd_addr_o,
    output logic [data_width_p-1:0]                iwb_data_o,

    output logic                                   fwb_v_o,
    output logic [reg_addr_width_p-1:0]            fwb_rd_addr_o,
    output logic [data_width_p-1:0]                fwb_data_o
);

    localparam int unsigned ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    // Channel 0 = iwb, channel 1 = fwb
    localparam int unsigned num_ch_lp    = 2;

    logic [num_ch_lp-1:0]                        busy;
    logic [num_ch_lp-1:0][num_req_p-1:0]         elig;
    logic [num_ch_lp-1:0]                        has_req;
    logic [num_ch_lp-1:0]                        grant;
    logic [num_ch_lp-1:0][ptr_width_lp-1:0]      win_idx;
    logic [num_ch_lp-1:0][reg_addr_width_p-1:0]  win_rd;
    logic [num_ch_lp-1:0][data_width_p-1:0]      win_data;

    logic [num_ch_lp-1:0][ptr_width_lp-1:0]      ptr_d, ptr_q;
    logic [num_ch_lp-1:0]                        out_v_d, out_v_q;
    logic [num_ch_lp-1:0][reg_addr_width_p-1:0]  out_rd_d, out_rd_q;
    logic [num_ch_lp-1:0][data_width_p-1:0]      out_data_d, out_data_q;

`ifdef BP_BE_LATE_WB_HOLD_EN
    logic [num_ch_lp-1:0]                        hold_v_d, hold_v_q;
    logic [num_ch_lp-1:0][reg_addr_width_p-1:0]  hold_rd_d, hold_rd_q;
    logic [num_ch_lp-1:0][data_width_p-1:0]      hold_data_d, hold_data_q;
`endif

    assign busy = {fwb_busy_i, iwb_busy_i};

    // Round-robin winner per channel: first eligible index at or after ptr
    always_comb begin
        int unsigned idx;
        idx      = 0;
        elig     = '0;
        has_req  = '0;
        win_idx  = '0;
        win_rd   = '0;
        win_data = '0;
        for (int unsigned c = 0; c < num_ch_lp; c++) begin
            elig[c] = req_v_i & ((c == 0) ? ~req_fp_i : req_fp_i);
            for (int unsigned k = 0; k < num_req_p; k++) begin
                idx = (32'(ptr_q[c]) + k) % num_req_p;
                if (!has_req[c] && elig[c][idx]) begin
                    has_req[c]  = 1'b1;
                    win_idx[c]  = ptr_width_lp'(idx);
                    win_rd[c]   = req_rd_addr_i[idx*reg_addr_width_p +: reg_addr_width_p];
                    win_data[c] = req_data_i[idx*data_width_p +: data_width_p];
                end
            end
        end
    end

    // Grant decision, output/hold register loads and pointer advance
    always_comb begin
        grant      = '0;
        out_v_d    = '0;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        ptr_d      = ptr_q;
`ifdef BP_BE_LATE_WB_HOLD_EN
        hold_v_d    = hold_v_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
`endif
        for (int unsigned c = 0; c < num_ch_lp; c++) begin
`ifdef BP_BE_LATE_WB_HOLD_EN
            // A full hold blocks new grants until it drains to the output
            if (hold_v_q[c]) begin
                if (!busy[c]) begin
                    out_v_d[c]    = 1'b1;
                    out_rd_d[c]   = hold_rd_q[c];
                    out_data_d[c] = hold_data_q[c];
                    hold_v_d[c]   = 1'b0;
                end
            end else if (has_req[c] && !reset_i) begin
                grant[c] = 1'b1;
                if (!busy[c]) begin
                    out_v_d[c]    = 1'b1;
                    out_rd_d[c]   = win_rd[c];
                    out_data_d[c] = win_data[c];
                end else begin
                    hold_v_d[c]    = 1'b1;
                    hold_rd_d[c]   = win_rd[c];
                    hold_data_d[c] = win_data[c];
                end
            end
`else
            if (has_req[c] && !busy[c] && !reset_i) begin
                grant[c]      = 1'b1;
                out_v_d[c]    = 1'b1;
                out_rd_d[c]   = win_rd[c];
                out_data_d[c] = win_data[c];
            end
`endif
            if (grant[c]) begin
                ptr_d[c] = (32'(win_idx[c]) == num_req_p - 1)
                         ? '0
                         : ptr_width_lp'(32'(win_idx[c]) + 1);
            end
        end
    end

    // Consume the winner of each granting channel
    always_comb begin
        req_yumi_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            for (int unsigned c = 0; c < num_ch_lp; c++) begin
                if (grant[c] && (32'(win_idx[c]) == i)) begin
                    req_yumi_o[i] = 1'b1;
                end
            end
        end
    end

    // Control state; a pending output or hold entry is dropped by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q    <= '0;
            out_v_q  <= '0;
`ifdef BP_BE_LATE_WB_HOLD_EN
            hold_v_q <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            out_v_q  <= out_v_d;
`ifdef BP_BE_LATE_WB_HOLD_EN
            hold_v_q <= hold_v_d;
`endif
        end
    end

    // Payload registers need no reset; they are qualified by the valids
    always_ff @(posedge clk_i) begin
        out_rd_q    <= out_rd_d;
        out_data_q  <= out_data_d;
`ifdef BP_BE_LATE_WB_HOLD_EN
        hold_rd_q   <= hold_rd_d;
        hold_data_q <= hold_data_d;
`endif
    end

    // Valids are forced low during the reset cycle itself
    assign iwb_v_o       = out_v_q[0] & ~reset_i;
    assign iwb_rd_addr_o = out_rd_q[0];
    assign iwb_data_o    = out_data_q[0];
    assign fwb_v_o       = out_v_q[1] & ~reset_i;
    assign fwb_rd_addr_o = out_rd_q[1];
    assign fwb_data_o    = out_data_q[1];

`ifndef SYNTHESIS
    // Producers must hold their request stable until consumed
    for (genvar i = 0; i < num_req_p; i++) begin : g_req_stable
        a_req_stable : assert property (@(posedge clk_i) disable iff (reset_i)
            (req_v_i[i] && !req_yumi_o[i]) |=>
            (req_v_i[i]
             && $stable(req_fp_i[i])
             && $stable(req_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p])
             && $stable(req_data_i[i*data_width_p +: data_width_p])));
    end
`endif

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bp_be_late_wb_arbiter
//
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the two round-robin writeback channels.
// ---------------------------------------------------------------------------
module tb_bp_be_late_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic clk;
    logic reset_i;

    logic [N-1:0]    p_v;
    logic [N-1:0]    p_fp;
    logic [AW-1:0]   p_rd   [N];
    logic [DW-1:0]   p_data [N];
    logic [N*AW-1:0] rd_flat;
    logic [N*DW-1:0] data_flat;
    logic [N-1:0]    yumi;
    logic            iwb_busy, fwb_busy;

    logic            iwb_v, fwb_v;
    logic [AW-1:0]   iwb_rd, fwb_rd;
    logic [DW-1:0]   iwb_data, fwb_data;

    // Reference model state per channel (0 = iwb, 1 = fwb)
    int              m_ptr    [2];
    bit              m_out_v  [2];
    logic [AW-1:0]   m_out_rd [2];
    logic [DW-1:0]   m_out_dat[2];
    bit              m_hv     [2];
    logic [AW-1:0]   m_hrd    [2];
    logic [DW-1:0]   m_hdat   [2];
    logic [N-1:0]    last_yumi;

    int checks;
    int errors;

    bp_be_late_wb_arbiter #(
        .num_req_p        (N),
        .data_width_p     (DW),
        .reg_addr_width_p (AW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_v_i       (p_v),
        .req_fp_i      (p_fp),
        .req_rd_addr_i (rd_flat),
        .req_data_i    (data_flat),
        .req_yumi_o    (yumi),
        .iwb_busy_i    (iwb_busy),
        .fwb_busy_i    (fwb_busy),
        .iwb_v_o       (iwb_v),
        .iwb_rd_addr_o (iwb_rd),
        .iwb_data_o    (iwb_data),
        .fwb_v_o       (fwb_v),
        .fwb_rd_addr_o (fwb_rd),
        .fwb_data_o    (fwb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_flat[i*AW +: AW]   = p_rd[i];
            data_flat[i*DW +: DW] = p_data[i];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check yumi and the registered packets against the
    // model at the falling edge, then advance the model and the clock.
    task automatic step();
        logic [N-1:0] ey;
        int           win [2];
        bit           found [2];
        bit           g [2];
        bit           bsy;
        int           idx;
        @(negedge clk);
        ey = '0;
        for (int c = 0; c < 2; c++) begin
            found[c] = 0;
            win[c]   = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr[c] + k) % N;
                if (!found[c] && p_v[idx] && (int'(p_fp[idx]) == c)) begin
                    found[c] = 1;
                    win[c]   = idx;
                end
            end
            bsy  = (c == 0) ? iwb_busy : fwb_busy;
            g[c] = 0;
            if (!reset_i) begin
`ifdef BP_BE_LATE_WB_HOLD_EN
                g[c] = found[c] && !m_hv[c];
`else
                g[c] = found[c] && !bsy;
`endif
            end
            if (g[c]) ey[win[c]] = 1'b1;
        end

        check_eq("yumi", 64'(yumi), 64'(ey));
        check_eq("iwb_v", 64'(iwb_v), reset_i ? 64'd0 : 64'(m_out_v[0]));
        check_eq("fwb_v", 64'(fwb_v), reset_i ? 64'd0 : 64'(m_out_v[1]));
        if (!reset_i && m_out_v[0]) begin
            check_eq("iwb_rd", 64'(iwb_rd), 64'(m_out_rd[0]));
            check_eq("iwb_data", iwb_data, m_out_dat[0]);
        end
        if (!reset_i && m_out_v[1]) begin
            check_eq("fwb_rd", 64'(fwb_rd), 64'(m_out_rd[1]));
            check_eq("fwb_data", fwb_data, m_out_dat[1]);
        end

        for (int c = 0; c < 2; c++) begin
            bsy = (c == 0) ? iwb_busy : fwb_busy;
            if (reset_i) begin
                m_ptr[c]   = 0;
                m_out_v[c] = 0;
                m_hv[c]    = 0;
            end else begin
`ifdef BP_BE_LATE_WB_HOLD_EN
                m_out_v[c] = 0;
                if (m_hv[c]) begin
                    if (!bsy) begin
                        m_out_v[c]   = 1;
                        m_out_rd[c]  = m_hrd[c];
                        m_out_dat[c] = m_hdat[c];
                        m_hv[c]      = 0;
                    end
                end else if (g[c]) begin
                    if (!bsy) begin
                        m_out_v[c]   = 1;
                        m_out_rd[c]  = p_rd[win[c]];
                        m_out_dat[c] = p_data[win[c]];
                    end else begin
                        m_hv[c]   = 1;
                        m_hrd[c]  = p_rd[win[c]];
                        m_hdat[c] = p_data[win[c]];
                    end
                end
`else
                m_out_v[c] = g[c];
                if (g[c]) begin
                    m_out_rd[c]  = p_rd[win[c]];
                    m_out_dat[c] = p_data[win[c]];
                end
`endif
                if (g[c]) m_ptr[c] = (win[c] + 1) % N;
            end
        end
        last_yumi = ey;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        p_v     = '0;
        step();
        reset_i = 1'b0;
    endtask

    // Consumed or idle producers may raise a fresh random request
    task automatic randomize_producers();
        for (int i = 0; i < N; i++) begin
            if (last_yumi[i] || !p_v[i]) begin
                if ($urandom_range(0, 9) < 6) begin
                    p_v[i]    = 1'b1;
                    p_fp[i]   = 1'($urandom_range(0, 1));
                    p_rd[i]   = AW'($urandom);
                    p_data[i] = {$urandom, $urandom};
                end else begin
                    p_v[i] = 1'b0;
                end
            end
        end
        iwb_busy = ($urandom_range(0, 3) == 0);
        fwb_busy = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        checks    = 0;
        errors    = 0;
        reset_i   = 1'b1;
        p_v       = '0;
        p_fp      = '0;
        iwb_busy  = 1'b0;
        fwb_busy  = 1'b0;
        last_yumi = '0;
        for (int i = 0; i < N; i++) begin
            p_rd[i]   = '0;
            p_data[i] = '0;
        end
        for (int c = 0; c < 2; c++) begin
            m_ptr[c] = 0; m_out_v[c] = 0; m_hv[c] = 0;
            m_out_rd[c] = '0; m_out_dat[c] = '0; m_hrd[c] = '0; m_hdat[c] = '0;
        end

        @(posedge clk);
        #1;
        step();
        reset_i = 1'b0;

        // Single integer request from idiv
        p_v = 3'b010; p_fp = 3'b000; p_rd[1] = 5'd7; p_data[1] = 64'hDEAD;
        #1;
        check_eq("single_yumi", 64'(yumi), 64'(3'b010));
        step();
        p_v = '0;
        #1;
        check_eq("single_iwb_v", 64'(iwb_v), 64'd1);
        check_eq("single_iwb_rd", 64'(iwb_rd), 64'd7);
        check_eq("single_iwb_data", iwb_data, 64'hDEAD);
        check_eq("single_fwb_v", 64'(fwb_v), 64'd0);
        step();
        check_eq("single_pulse", 64'(iwb_v), 64'd0);

        // Round-robin among three continuous integer requesters
        do_reset();
        p_v = 3'b111; p_fp = 3'b000;
        for (int i = 0; i < N; i++) begin
            p_rd[i]   = AW'(10 + i);
            p_data[i] = 64'(100 + i);
        end
        for (int n = 0; n < 4; n++) begin
            #1;
            check_eq("rr_yumi", 64'(yumi), 64'(rr_exp[n]));
            step();
        end

        // Both channels granted in the same cycle
        do_reset();
        p_v = 3'b101; p_fp = 3'b100;
        p_rd[0] = 5'd3; p_data[0] = 64'h3333;
        p_rd[2] = 5'd9; p_data[2] = 64'h9999;
        #1;
        check_eq("dual_yumi", 64'(yumi), 64'(3'b101));
        step();
        p_v = '0;
        #1;
        check_eq("dual_iwb_v", 64'(iwb_v), 64'd1);
        check_eq("dual_iwb_rd", 64'(iwb_rd), 64'd3);
        check_eq("dual_fwb_v", 64'(fwb_v), 64'd1);
        check_eq("dual_fwb_rd", 64'(fwb_rd), 64'd9);
        step();

        // Busy stall on the integer channel
        p_v = 3'b010; p_fp = 3'b000; p_rd[1] = 5'd12; p_data[1] = 64'hBEEF;
        iwb_busy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
`ifdef BP_BE_LATE_WB_HOLD_EN
            check_eq("stall_yumi", 64'(yumi), (n == 0) ? 64'(3'b010) : 64'd0);
            step();
            p_v = '0;
`else
            check_eq("stall_yumi", 64'(yumi), 64'd0);
            step();
`endif
        end
        iwb_busy = 1'b0;
        #1;
`ifdef BP_BE_LATE_WB_HOLD_EN
        check_eq("stall_release_yumi", 64'(yumi), 64'd0);
        step();
`else
        check_eq("stall_release_yumi", 64'(yumi), 64'(3'b010));
        step();
        p_v = '0;
`endif
        #1;
        check_eq("stall_iwb_v", 64'(iwb_v), 64'd1);
        check_eq("stall_iwb_rd", 64'(iwb_rd), 64'd12);
        step();

        // Reset right after a grant drops the pending writeback
        do_reset();
        p_v = 3'b001; p_fp = 3'b000; p_rd[0] = 5'd1; p_data[0] = 64'h1;
        #1;
        check_eq("rst_grant_yumi", 64'(yumi), 64'(3'b001));
        step();
        p_v = '0;
        reset_i = 1'b1;
        #1;
        check_eq("rst_v_n1", 64'(iwb_v), 64'd0);
        step();
        reset_i = 1'b0;
        #1;
        check_eq("rst_v_n2", 64'(iwb_v), 64'd0);
        p_v = 3'b110; p_fp = 3'b000;
        #1;
        check_eq("rst_first_grant", 64'(yumi), 64'(3'b010));
        step();

`ifdef BP_BE_LATE_WB_HOLD_EN
        // Full hold blocks new grants until it drains
        do_reset();
        iwb_busy = 1'b1;
        p_v = 3'b001; p_fp = 3'b000; p_rd[0] = 5'd4; p_data[0] = 64'h44;
        #1;
        check_eq("hold_fill_yumi", 64'(yumi), 64'(3'b001));
        step();
        p_rd[0] = 5'd5; p_data[0] = 64'h55;
        #1;
        check_eq("hold_full_yumi", 64'(yumi), 64'd0);
        step();
        iwb_busy = 1'b0;
        #1;
        check_eq("hold_drain_yumi", 64'(yumi), 64'd0);
        step();
        #1;
        check_eq("hold_out_v", 64'(iwb_v), 64'd1);
        check_eq("hold_out_rd", 64'(iwb_rd), 64'd4);
        check_eq("hold_next_yumi", 64'(yumi), 64'(3'b001));
        step();
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            randomize_producers();
            reset_i = ($urandom_range(0, 199) == 0);
            step();
        end
        reset_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
